// File: rtl/cache_arb_pkg.sv
// Shared types and default sizing for the cache-to-memory arbiter.
package cache_arb_pkg;

  localparam int MEM_LATENCY_DEF = 4;
  localparam int BURST_WORDS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    DRAIN
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

endpackage

// File: rtl/arb_latency_pipe.sv
// Owner-tagged shift register mirroring the memory read latency; the tail entry
// lines up with mem_rdata_valid for a read pushed DEPTH cycles earlier (DEPTH >= 2).
module arb_latency_pipe
  import cache_arb_pkg::*;
#(
  parameter int DEPTH = MEM_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic push_owner_i,
  output logic tail_vld_o,
  output logic tail_owner_o,
  output logic empty_o
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] own_q;

  // Shifts every cycle; cycles without an issue insert a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      own_q <= '0;
    end else begin
      vld_q <= {vld_q[DEPTH-2:0], push_i};
      own_q <= {own_q[DEPTH-2:0], push_owner_i};
    end
  end

  assign tail_vld_o   = vld_q[DEPTH-1];
  assign tail_owner_o = own_q[DEPTH-1];
  assign empty_o      = ~|vld_q;

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-fill, D-fill and D write-through stores onto one pipelined memory.
// Define CACHE_ARB_FAIR_EN for round-robin I/D tie-break; default is D over I.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DEF,
  parameter int BURST_WORDS = BURST_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_busy,
  output logic        i_data_valid,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  output logic        d_busy,
  output logic        d_data_valid,
  input  logic        d_wr_en,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  output logic        d_wr_stall,
  output logic [15:0] rd_data,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rdata_valid
);

  localparam int CW = $clog2(BURST_WORDS) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_WORDS - 1);

  arb_state_t    state_q, state_d;
  owner_t        burst_q, burst_d;
  owner_t        last_grant_q, last_grant_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        push;
  logic        push_owner;
  logic        tail_vld;
  logic        tail_owner;
  logic        pipe_empty;
  logic        gnt_req;
  logic [15:0] gnt_addr;
  logic        d_wins;

  assign gnt_req    = (state_q == GRANT_I) ? i_req : d_req;
  assign gnt_addr   = (state_q == GRANT_I) ? i_addr : d_addr;
  assign push_owner = (state_q == GRANT_D);

`ifdef CACHE_ARB_FAIR_EN
  // On a tie the requester that did not own the previous burst goes first.
  assign d_wins = d_req && !(i_req && (last_grant_q == OWN_D));
`else
  assign d_wins = d_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      burst_q      <= OWN_I;
      last_grant_q <= OWN_I;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      burst_q      <= burst_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    burst_d      = burst_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    d_wr_stall   = 1'b0;
    push         = 1'b0;

    unique case (state_q)
      IDLE: begin
        // IDLE is only reachable with an empty pipe, so a store never overtakes a read.
        if (d_wr_en) begin
          mem_enable = 1'b1;
          mem_wr     = 1'b1;
          mem_addr   = d_wr_addr;
          mem_wdata  = d_wr_data;
        end else if (d_wins) begin
          state_d = GRANT_D;
          burst_d = OWN_D;
          cnt_d   = '0;
        end else if (i_req) begin
          state_d = GRANT_I;
          burst_d = OWN_I;
          cnt_d   = '0;
        end
      end
      GRANT_I, GRANT_D: begin
        d_wr_stall = d_wr_en;
        if (!gnt_req) begin
          state_d = DRAIN;
        end else begin
          mem_enable = 1'b1;
          mem_addr   = gnt_addr;
          push       = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        d_wr_stall = d_wr_en;
        if (pipe_empty) begin
          state_d      = IDLE;
          last_grant_d = burst_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  arb_latency_pipe #(
    .DEPTH(MEM_LATENCY)
  ) u_pipe (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_owner_i (push_owner),
    .tail_vld_o   (tail_vld),
    .tail_owner_o (tail_owner),
    .empty_o      (pipe_empty)
  );

  assign i_busy  = (state_q != GRANT_I);
  assign d_busy  = (state_q != GRANT_D);
  assign rd_data = mem_rdata;

  // Returns with no tagged tail entry (stray or post-reset) are dropped.
  assign i_data_valid = mem_rdata_valid & tail_vld & (owner_t'(tail_owner) == OWN_I) & ~rst;
  assign d_data_valid = mem_rdata_valid & tail_vld & (owner_t'(tail_owner) == OWN_D) & ~rst;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter with a 4-cycle pipelined memory model.
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr_en;
  logic [15:0] i_addr, d_addr, d_wr_addr, d_wr_data;
  logic        i_busy, d_busy, i_data_valid, d_data_valid, d_wr_stall;
  logic [15:0] rd_data, mem_addr, mem_wdata, mem_rdata;
  logic        mem_enable, mem_wr, mem_rdata_valid;
  logic        mdl_vld, inj_vld;

  always #5 clk = ~clk;

  assign mem_rdata_valid = mdl_vld | inj_vld;

  cache_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_busy(i_busy), .i_data_valid(i_data_valid),
    .d_req(d_req), .d_addr(d_addr), .d_busy(d_busy), .d_data_valid(d_data_valid),
    .d_wr_en(d_wr_en), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data), .d_wr_stall(d_wr_stall),
    .rd_data(rd_data), .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid)
  );

  typedef struct { logic wr; logic [15:0] addr; logic [15:0] wdata; } mexp_t;
  typedef struct { logic own_d; logic [15:0] data; } dexp_t;

  mexp_t mq[$];
  dexp_t dq[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  task automatic expect_burst(input logic own_d, input logic [15:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      mq.push_back('{1'b0, base + 16'(2 * k), 16'h0000});
      dq.push_back('{own_d, mem_fn(base + 16'(2 * k))});
    end
  endtask

  // Memory: a read seen in cycle t returns mem_fn(addr) with valid in cycle t+4.
  initial begin : mem_model
    logic [3:0]  mp_v;
    logic [15:0] mp_a [0:3];
    logic        iv;
    logic [15:0] ia;
    mp_v = '0;
    for (int k = 0; k < 4; k++) mp_a[k] = '0;
    mdl_vld   = 1'b0;
    mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      iv = mem_enable && !mem_wr;
      ia = mem_addr;
      @(posedge clk);
      #1;
      mp_v    = {mp_v[2:0], iv};
      mp_a[3] = mp_a[2];
      mp_a[2] = mp_a[1];
      mp_a[1] = mp_a[0];
      mp_a[0] = ia;
      mdl_vld   = mp_v[3];
      mem_rdata = mp_v[3] ? mem_fn(mp_a[3]) : 16'hDEAD;
    end
  end

  initial begin : monitor
    mexp_t me;
    dexp_t de;
    forever begin
      @(negedge clk);
      if (mem_enable) begin
        if (mq.size() == 0) flag("mem_unexpected");
        else begin
          me = mq.pop_front();
          check("mem_wr", 16'(mem_wr), 16'(me.wr));
          check("mem_addr", mem_addr, me.addr);
          if (me.wr) check("mem_wdata", mem_wdata, me.wdata);
        end
      end
      if (i_data_valid && d_data_valid) flag("dv_both");
      if (i_data_valid || d_data_valid) begin
        if (dq.size() == 0) flag("dv_unexpected");
        else begin
          de = dq.pop_front();
          check("dv_owner_d", 16'(d_data_valid), 16'(de.own_d));
          check("rd_data", rd_data, de.data);
        end
      end
    end
  end

  task automatic fill_i(input logic [15:0] base, input int n);
    int k = 0;
    int t = 0;
    logic g;
    i_addr = base;
    i_req  = 1'b1;
    while (k < n && t < 100) begin
      @(negedge clk);
      g = !i_busy;
      @(posedge clk);
      #1;
      if (g) begin
        k++;
        i_addr = base + 16'(2 * k);
      end
      t++;
    end
    i_req = 1'b0;
    if (k < n) flag("fill_i_timeout");
  endtask

  task automatic fill_d(input logic [15:0] base, input int n);
    int k = 0;
    int t = 0;
    logic g;
    d_addr = base;
    d_req  = 1'b1;
    while (k < n && t < 100) begin
      @(negedge clk);
      g = !d_busy;
      @(posedge clk);
      #1;
      if (g) begin
        k++;
        d_addr = base + 16'(2 * k);
      end
      t++;
    end
    d_req = 1'b0;
    if (k < n) flag("fill_d_timeout");
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((mq.size() != 0 || dq.size() != 0) && t < 60) begin
      @(posedge clk);
      t++;
    end
    if (mq.size() != 0 || dq.size() != 0) flag("drain_timeout");
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_enable"}, 16'(mem_enable), 16'h0);
    check({tag, "_mem_wr"}, 16'(mem_wr), 16'h0);
    check({tag, "_mem_addr"}, mem_addr, 16'h0000);
    check({tag, "_mem_wdata"}, mem_wdata, 16'h0000);
    check({tag, "_i_dv"}, 16'(i_data_valid), 16'h0);
    check({tag, "_d_dv"}, 16'(d_data_valid), 16'h0);
    check({tag, "_i_busy"}, 16'(i_busy), 16'h1);
    check({tag, "_d_busy"}, 16'(d_busy), 16'h1);
    check({tag, "_wr_stall"}, 16'(d_wr_stall), 16'h0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int   t;
    int   g;
    logic st;
    logic first;
    rst = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_wr_en = 1'b0;
    i_addr = '0; d_addr = '0; d_wr_addr = '0; d_wr_data = '0;
    inj_vld = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst0");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // I miss alone: 8 reads, 8 I returns, no D returns.
    expect_burst(1'b0, 16'h1230, 8);
    fill_i(16'h1230, 8);
    wait_drain();

    // D burst abandoned after 3 issues.
    expect_burst(1'b1, 16'h4000, 3);
    fill_d(16'h4000, 3);
    wait_drain();

    // Simultaneous requests with last_grant = D.
`ifdef CACHE_ARB_FAIR_EN
    expect_burst(1'b0, 16'h1230, 8);
    expect_burst(1'b1, 16'h4000, 8);
`else
    expect_burst(1'b1, 16'h4000, 8);
    expect_burst(1'b0, 16'h1230, 8);
`endif
    fork
      fill_d(16'h4000, 8);
      fill_i(16'h1230, 8);
    join
    wait_drain();

    // Store during a D burst waits out the drain, then issues in IDLE.
    expect_burst(1'b1, 16'h4000, 8);
    mq.push_back('{1'b1, 16'h0200, 16'hBEEF});
    fork
      fill_d(16'h4000, 8);
      begin
        repeat (3) @(posedge clk);
        #1;
        d_wr_addr = 16'h0200;
        d_wr_data = 16'hBEEF;
        d_wr_en   = 1'b1;
        t = 0;
        first = 1'b1;
        st = 1'b1;
        while (st && t < 60) begin
          @(negedge clk);
          st = d_wr_stall;
          if (first) check("wr_stall_in_burst", 16'(st), 16'h1);
          if (!st) check("wr_after_drain_dq", 16'(dq.size()), 16'h0);
          first = 1'b0;
          @(posedge clk);
          #1;
          t++;
        end
        d_wr_en = 1'b0;
        if (st) flag("store_timeout");
      end
    join
    wait_drain();

    // Reset two issues into an I burst; late returns must be dropped.
    mq.push_back('{1'b0, 16'h1230, 16'h0000});
    mq.push_back('{1'b0, 16'h1232, 16'h0000});
    i_addr = 16'h1230;
    i_req  = 1'b1;
    g = 0;
    t = 0;
    while (g < 2 && t < 20) begin
      @(negedge clk);
      if (!i_busy) g++;
      @(posedge clk);
      #1;
      if (g == 1) i_addr = 16'h1232;
      t++;
    end
    if (g < 2) flag("rst_burst_timeout");
    rst   = 1'b1;
    i_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("late_i_dv", 16'(i_data_valid), 16'h0);
      check("late_d_dv", 16'(d_data_valid), 16'h0);
    end
    wait_drain();

    // Stray mem_rdata_valid with an empty pipe.
    inj_vld = 1'b1;
    @(negedge clk);
    check("stray_i_dv", 16'(i_data_valid), 16'h0);
    check("stray_d_dv", 16'(d_data_valid), 16'h0);
    @(posedge clk);
    #1;
    inj_vld = 1'b0;

    repeat (4) @(posedge clk);
    check("mq_left", 16'(mq.size()), 16'h0);
    check("dq_left", 16'(dq.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sits directly downstream of the I-cache and D-cache fill FSMs.
- Arbitrates both FSMs, plus D-cache write-through stores, onto the single shared 4-cycle pipelined main memory.
- Drives each FSM's memory_busy input and routes returning read data and its valid back to the FSM that owns the request.
- Tracks in-flight reads with an owner-tagged latency pipe.

Parameters:
- MEM_LATENCY, 4: cycles from read issue to mem_rdata_valid.
- BURST_WORDS, 8: reads per block fill (16-byte block, 2-byte words).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req  in  1  I-cache fill request (I-FSM miss_detected)
- i_addr  in  16  I-FSM memory_address, sampled every granted cycle
- i_busy  out  1  to I-FSM memory_busy; high while memory not granted to I
- i_data_valid  out  1  to I-FSM memory_data_valid
- d_req  in  1  D-cache fill request
- d_addr  in  16  D-FSM memory_address
- d_busy  out  1  to D-FSM memory_busy
- d_data_valid  out  1  to D-FSM memory_data_valid
- d_wr_en  in  1  write-through store request
- d_wr_addr  in  16  store address
- d_wr_data  in  16  store data
- d_wr_stall  out  1  store not accepted this cycle; requester holds inputs
- rd_data  out  16  mem_rdata broadcast to both FSMs
- mem_enable  out  1  memory access strobe
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_rdata_valid  in  1  memory read data valid

Behaviour:
- Reset: state IDLE; latency pipe cleared; issue counter 0; last_grant = I.
  - Outputs at reset: mem_enable, mem_wr, i_data_valid, d_data_valid = 0; mem_addr, mem_wdata = 0; i_busy = d_busy = 1; d_wr_stall = 0.
- States: IDLE, GRANT_I, GRANT_D, DRAIN.
- IDLE, priority in this order:
  - d_wr_en: single-cycle write (mem_enable=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data, d_wr_stall=0); stay IDLE.
  - Else d_req: go to GRANT_D.
  - Else i_req: go to GRANT_I.
  - Both busy outputs stay high in IDLE.
- Grant timing: the busy output of the granted requester drops the cycle after grant is decided.
- GRANT_x:
  - Each cycle: mem_enable=1, mem_wr=0, mem_addr=x_addr; issue counter increments; push {valid=1, owner=x} into the latency pipe.
  - Leave to DRAIN after BURST_WORDS issues, or immediately if x_req deasserts (no issue that cycle).
  - The non-granted busy and d_wr_stall (when d_wr_en=1) are held high throughout.
- DRAIN:
  - No issues; d_wr_stall=1 on d_wr_en.
  - Return to IDLE when the pipe is empty; set last_grant = owner of the drained burst.
- Latency pipe: MEM_LATENCY deep, shifts every cycle (bubbles push valid=0).
  - Tail entry valid & owner=I gives i_data_valid = mem_rdata_valid; same for D.
  - mem_rdata_valid with an empty tail entry is ignored.
- Writes are never issued while any read is outstanding. Write data is registered into memory the same cycle.
- Simultaneous d_req and i_req in IDLE: D wins (CACHE_ARB_FAIR_EN changes this).
- Reset mid-burst: pipe flushed; late mem_rdata_valid produces no *_data_valid.
- Counter width is $clog2(BURST_WORDS)+1 bits. Wrap never occurs because the counter clears on entry to GRANT_x.

Optional Feature:
- CACHE_ARB_FAIR_EN defined: IDLE tie-break is round-robin. The requester that is not last_grant wins when both request; writes keep top priority.
- Undefined: fixed priority, D over I. A continuously requesting D may starve I.

Decomposition:
- Package cache_arb_pkg holds:
  - typedef arb_state_t {IDLE, GRANT_I, GRANT_D, DRAIN};
  - typedef owner_t {OWN_I, OWN_D};
  - constants MEM_LATENCY_DEF=4, BURST_WORDS_DEF=8.
- Sub-module: arb_latency_pipe, a parameterised owner-tagged shift register with push/valid/owner at the tail.

Test Plan:
- I miss alone, i_addr 0x1230..0x123E over 8 cycles -> 8 reads; i_data_valid high 4 cycles after each issue, 8 pulses; d_data_valid never asserted; back to IDLE after drain.
- d_req and i_req both asserted in the same IDLE cycle:
  - macro off -> D burst (0x4000..0x400E) completes first, then I burst.
  - macro on, last_grant=D -> I first.
- Store 0xBEEF to 0x0200 during a D burst -> d_wr_stall high until DRAIN ends; write issued first IDLE cycle with mem_wr=1, mem_wdata=0xBEEF.
- d_req drops after 3 issues -> DRAIN; exactly 3 d_data_valid pulses; pipe empties in 4 cycles.
- rst asserted 2 cycles into an I burst, memory still returns 2 valids -> no *_data_valid; all outputs at reset values.
- mem_rdata_valid injected with an empty pipe -> both *_data_valid stay 0.
